ipml_mc_fifo_v2_0: RTL and testbench
====================================

// Module: ipml_mc_fifo_v2_0
// PURPOSE
//  Single-clock, multi-channel FIFO: C_CH_NUM independent FIFOs share one inferred RAM partitioned per channel.
//  Successor to the single-channel sync FIFO: adds a channel select on each side, per-channel flags, flush and output tagging.
//  Sits between the HSST receive de-mux and the per-lane consumers.
// PARAMETERS
//  C_CH_NUM            4    number of channels, 1..16
//  C_DATA_WIDTH        16   data width, 1..256
//  C_DEPTH_WIDTH       8    log2 of per-channel depth; depth D = 2**C_DEPTH_WIDTH
//  C_ALMOST_FULL_NUM   252  almost_full[c] = 1 when count[c] >= this value
//  C_ALMOST_EMPTY_NUM  4    almost_empty[c] = 1 when count[c] <= this value
// PORTS
//  clk           in   1                        single clock
//  rst_n         in   1                        asynchronous reset, active low
//  wr_en         in   1                        write request
//  wr_ch         in   CHW                      write channel; CHW = max(1, clog2(C_CH_NUM))
//  wr_data       in   C_DATA_WIDTH             write data
//  rd_en         in   1                        read request
//  rd_ch         in   CHW                      read channel
//  rd_valid      out  1                        rd_data/rd_data_ch valid this cycle
//  rd_data       out  C_DATA_WIDTH             read data
//  rd_data_ch    out  CHW                      channel of rd_data
//  ch_flush      in   C_CH_NUM                 per-channel synchronous flush
//  full          out  C_CH_NUM                 per-channel full
//  empty         out  C_CH_NUM                 per-channel empty
//  almost_full   out  C_CH_NUM                 per-channel almost full
//  almost_empty  out  C_CH_NUM                 per-channel almost empty
//  overflow      out  C_CH_NUM                 sticky error flag (IPML_MC_FIFO_ERR_FLAG_EN only)
//  underflow     out  C_CH_NUM                 sticky error flag (IPML_MC_FIFO_ERR_FLAG_EN only)
//  err_clr       in   1                        clears the sticky flags (IPML_MC_FIFO_ERR_FLAG_EN only)
// BEHAVIOUR
//  - Clock: one clock, clk. Reset: rst_n is asynchronous and active-low.
//  - Reset: all pointers and counts = 0; empty = all 1; almost_empty = all 1; full = 0; almost_full = 0.
//    rd_valid = 0, rd_data = 0, rd_data_ch = 0. RAM contents are not reset.
//  - Per-channel state: wptr, rptr (C_DEPTH_WIDTH bits, wrap modulo D) and count (C_DEPTH_WIDTH+1 bits).
//  - RAM address = {ch, ptr}.
//  - Write accept: wr_en & ~full[wr_ch] & ~ch_flush[wr_ch]. Stores data at {wr_ch, wptr}; wptr++.
//    A write to a full channel is dropped; no state changes.
//  - Read accept: rd_en & ~empty[rd_ch] & ~ch_flush[rd_ch]. Reads {rd_ch, rptr}; rptr++.
//    rd_valid, rd_data and rd_data_ch appear exactly 1 cycle after acceptance. A read of an empty channel is dropped; rd_valid stays 0.
//  - Flags are registered and derive from the post-update count, so they are valid the cycle after the event.
//    full = (count == D); empty = (count == 0).
//  - A write into an empty channel cannot be read until the next cycle, because empty is still 1.
//    No RAM read-during-write to the same address can occur.
//  - Same-channel write and read in one cycle: both are accepted if flags allow; count is unchanged.
//  - Different-channel write and read in one cycle: independent updates.
//  - ch_flush[c]: wptr = rptr = count = 0 next cycle; empty = 1, full = 0. Flush overrides any same-cycle access on c.
//    A read accepted the cycle before the flush still returns rd_valid.
//  - wr_ch or rd_ch >= C_CH_NUM: the access is ignored.
//  - rst_n asserted mid-operation: immediate return to reset values; an in-flight rd_valid is cancelled.
// CONFIGURATION
//  - `define IPML_MC_FIFO_ERR_FLAG_EN present:
//    overflow[c] sets on a write dropped because full[c]; underflow[c] sets on a read dropped because empty[c].
//    Both flags are cleared by err_clr or rst_n; a set event in the same cycle as err_clr wins.
//  - Absent: overflow and underflow are tied to 0, err_clr is ignored, and no error registers are built.
// STRUCTURE
//  - Package ipml_mc_fifo_pkg: clog2 function; CHW, RAM_AW = CHW + C_DEPTH_WIDTH; count-width localparams.
//  - Sub-module ipml_mc_fifo_ram: simple dual-port RAM, C_CH_NUM*D x C_DATA_WIDTH, registered 1-cycle read, no reset.
//  - Top level: per-channel pointer/count generate loop, flag registers, output valid/channel pipeline.
// TESTING
//  - Reset: after rst_n low then high, empty = 4'b1111, full = 0, rd_valid = 0.
//  - Fill ch2: 256 writes -> full[2] = 1 next cycle, almost_full[2] rose after the 252nd write.
//    A 257th write is dropped; overflow[2] = 1 when ERR_FLAG_EN is defined.
//  - Interleave: write A0..A3 to ch0 and B0..B3 to ch3, then read alternately.
//    Output is A0,B0,A1,B1,... with rd_data_ch 0,3,0,3,..., each 1 cycle after rd_en.
//  - Same-cycle write + read on ch1 with count = 5: count stays 5; data order is preserved across pointer wrap at 255 -> 0.
//  - Flush ch1 with count 10 while simultaneously writing ch1 and reading ch0:
//    ch1 becomes empty and the write is dropped; the ch0 read returns normally.
//  - Read empty ch0: rd_valid = 0, pointers unchanged; underflow[0] = 1, then err_clr -> 0.

Source files
------------

// File: rtl/ipml_mc_fifo_pkg.sv
// Shared helpers for the multi-channel FIFO.
// Contents: clog2/ch_width/cnt_width helpers and default-configuration widths.
// Optional feature macro used by the top level: IPML_MC_FIFO_ERR_FLAG_EN.
package ipml_mc_fifo_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel-select width; a single channel still needs one select bit.
    function automatic int unsigned ch_width(input int unsigned ch_num);
        return (clog2(ch_num) == 0) ? 1 : clog2(ch_num);
    endfunction

    // Count must hold 0..D inclusive, hence one bit wider than a pointer.
    function automatic int unsigned cnt_width(input int unsigned depth_width);
        return depth_width + 1;
    endfunction

    localparam int unsigned DEF_CH_NUM      = 4;
    localparam int unsigned DEF_DEPTH_WIDTH = 8;
    localparam int unsigned CHW             = ch_width(DEF_CH_NUM);
    localparam int unsigned RAM_AW          = CHW + DEF_DEPTH_WIDTH;
    localparam int unsigned CNT_W           = cnt_width(DEF_DEPTH_WIDTH);

endpackage

// File: rtl/ipml_mc_fifo_ram.sv
// Simple dual-port RAM shared by all FIFO channels.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read port;
//        rd_data registered one cycle after rd_en. Contents are not reset.
module ipml_mc_fifo_ram
    import ipml_mc_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Sized to the full address space; words above C_CH_NUM*D are never addressed
    // and are trimmed by synthesis.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ipml_mc_fifo_v2_0.sv
// Single-clock multi-channel FIFO: C_CH_NUM independent FIFOs in one shared RAM.
// Ports: clk, rst_n (async, active low); wr_en/wr_ch/wr_data write side;
//        rd_en/rd_ch read request, rd_valid/rd_data/rd_data_ch one cycle later;
//        ch_flush per-channel flush; full/empty/almost_full/almost_empty per channel;
//        overflow/underflow sticky errors and err_clr, built only when
//        IPML_MC_FIFO_ERR_FLAG_EN is defined (otherwise tied to 0).
module ipml_mc_fifo_v2_0
    import ipml_mc_fifo_pkg::*;
#(
    parameter int unsigned C_CH_NUM           = 4,
    parameter int unsigned C_DATA_WIDTH       = 16,
    parameter int unsigned C_DEPTH_WIDTH      = 8,
    parameter int unsigned C_ALMOST_FULL_NUM  = 252,
    parameter int unsigned C_ALMOST_EMPTY_NUM = 4,
    localparam int unsigned CHW               = ch_width(C_CH_NUM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [CHW-1:0]          wr_ch,
    input  logic [C_DATA_WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [CHW-1:0]          rd_ch,
    output logic                    rd_valid,
    output logic [C_DATA_WIDTH-1:0] rd_data,
    output logic [CHW-1:0]          rd_data_ch,
    input  logic [C_CH_NUM-1:0]     ch_flush,
    output logic [C_CH_NUM-1:0]     full,
    output logic [C_CH_NUM-1:0]     empty,
    output logic [C_CH_NUM-1:0]     almost_full,
    output logic [C_CH_NUM-1:0]     almost_empty,
    output logic [C_CH_NUM-1:0]     overflow,
    output logic [C_CH_NUM-1:0]     underflow,
    input  logic                    err_clr
);

    localparam int unsigned DEPTH     = 2 ** C_DEPTH_WIDTH;
    localparam int unsigned CW        = cnt_width(C_DEPTH_WIDTH);
    localparam int unsigned AW        = CHW + C_DEPTH_WIDTH;
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL  = CW'(C_ALMOST_FULL_NUM);
    localparam logic [CW-1:0] CNT_AEMPTY = CW'(C_ALMOST_EMPTY_NUM);

    logic [C_CH_NUM-1:0] wr_sel, rd_sel, wr_acc, rd_acc;
    logic [C_CH_NUM-1:0] full_q, empty_q, afull_q, aempty_q;
    logic [C_CH_NUM-1:0] full_d, empty_d, afull_d, aempty_d;
    logic [C_DEPTH_WIDTH-1:0] wptr_q [C_CH_NUM];
    logic [C_DEPTH_WIDTH-1:0] wptr_d [C_CH_NUM];
    logic [C_DEPTH_WIDTH-1:0] rptr_q [C_CH_NUM];
    logic [C_DEPTH_WIDTH-1:0] rptr_d [C_CH_NUM];
    logic [CW-1:0]            cnt_q  [C_CH_NUM];
    logic [CW-1:0]            cnt_d  [C_CH_NUM];
    logic [C_DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                     rd_valid_q;
    logic [CHW-1:0]           rd_ch_q;
    logic [C_DATA_WIDTH-1:0]  ram_rdata;

    // Channel decode by equality: selects >= C_CH_NUM match nothing and are ignored.
    always_comb begin
        wr_sel   = '0;
        rd_sel   = '0;
        wr_acc   = '0;
        rd_acc   = '0;
        full_d   = '0;
        empty_d  = '0;
        afull_d  = '0;
        aempty_d = '0;
        wr_ptr   = '0;
        rd_ptr   = '0;
        for (int c = 0; c < C_CH_NUM; c++) begin
            wptr_d[c] = wptr_q[c];
            rptr_d[c] = rptr_q[c];
            cnt_d[c]  = cnt_q[c];
            wr_sel[c] = wr_en && (wr_ch == CHW'(c));
            rd_sel[c] = rd_en && (rd_ch == CHW'(c));
            wr_acc[c] = wr_sel[c] && !full_q[c] && !ch_flush[c];
            rd_acc[c] = rd_sel[c] && !empty_q[c] && !ch_flush[c];
            if (wr_sel[c]) begin
                wr_ptr = wptr_q[c];
            end
            if (rd_sel[c]) begin
                rd_ptr = rptr_q[c];
            end
            if (ch_flush[c]) begin
                wptr_d[c] = '0;
                rptr_d[c] = '0;
                cnt_d[c]  = '0;
            end else begin
                wptr_d[c] = wptr_q[c] + C_DEPTH_WIDTH'(wr_acc[c]);
                rptr_d[c] = rptr_q[c] + C_DEPTH_WIDTH'(rd_acc[c]);
                cnt_d[c]  = cnt_q[c] + CW'(wr_acc[c]) - CW'(rd_acc[c]);
            end
            // Flags are registered from the post-update count.
            full_d[c]   = (cnt_d[c] == CNT_FULL);
            empty_d[c]  = (cnt_d[c] == '0);
            afull_d[c]  = (cnt_d[c] >= CNT_AFULL);
            aempty_d[c] = (cnt_d[c] <= CNT_AEMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < C_CH_NUM; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            full_q     <= '0;
            empty_q    <= '1;
            afull_q    <= '0;
            aempty_q   <= '1;
            rd_valid_q <= 1'b0;
            rd_ch_q    <= '0;
        end else begin
            for (int c = 0; c < C_CH_NUM; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            rd_valid_q <= |rd_acc;
            if (|rd_acc) begin
                rd_ch_q <= rd_ch;
            end
        end
    end

    ipml_mc_fifo_ram #(
        .DATA_W (C_DATA_WIDTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (|wr_acc),
        .wr_addr ({wr_ch, wr_ptr}),
        .wr_data (wr_data),
        .rd_en   (|rd_acc),
        .rd_addr ({rd_ch, rd_ptr}),
        .rd_data (ram_rdata)
    );

    // RAM output is not reset; gating keeps rd_data at 0 in reset and when idle.
    assign rd_data      = rd_valid_q ? ram_rdata : '0;
    assign rd_valid     = rd_valid_q;
    assign rd_data_ch   = rd_ch_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

`ifdef IPML_MC_FIFO_ERR_FLAG_EN
    logic [C_CH_NUM-1:0] ovf_set, unf_set, ovf_q, unf_q;

    // A flushed channel drops accesses because of the flush, not because of a flag.
    assign ovf_set = wr_sel & full_q & ~ch_flush;
    assign unf_set = rd_sel & empty_q & ~ch_flush;

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~{C_CH_NUM{err_clr}});
            unf_q <= unf_set | (unf_q & ~{C_CH_NUM{err_clr}});
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = '0;
    assign underflow      = '0;
`endif

endmodule

// File: tb/tb_ipml_mc_fifo_v2_0.sv
// Bench for ipml_mc_fifo_v2_0: directed scenarios plus random traffic checked
// against per-channel queue model.
module tb_ipml_mc_fifo_v2_0;

    localparam int CH = 4;
    localparam int DW = 16;
    localparam int D  = 256;
    localparam int AF = 252;
    localparam int AE = 4;
`ifdef IPML_MC_FIFO_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_ch = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [1:0]    rd_ch = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_data_ch;
    logic [CH-1:0] ch_flush = '0;
    logic [CH-1:0] full, empty, almost_full, almost_empty, overflow, underflow;
    logic          err_clr = 1'b0;

    always #5 clk = ~clk;

    ipml_mc_fifo_v2_0 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_ch        (rd_ch),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_data_ch   (rd_data_ch),
        .ch_flush     (ch_flush),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue per channel plus sticky error bits.
    logic [DW-1:0] mq [CH][$];
    logic [CH-1:0] m_ovf = '0;
    logic [CH-1:0] m_unf = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [CH-1:0] ef, ff, af, ae;
        for (int c = 0; c < CH; c++) begin
            ef[c] = (mq[c].size() == 0);
            ff[c] = (mq[c].size() == D);
            af[c] = (mq[c].size() >= AF);
            ae[c] = (mq[c].size() <= AE);
        end
        check_val("empty", 32'(empty), 32'(ef));
        check_val("full", 32'(full), 32'(ff));
        check_val("almost_full", 32'(almost_full), 32'(af));
        check_val("almost_empty", 32'(almost_empty), 32'(ae));
        check_val("overflow", 32'(overflow), ERR_EN ? 32'(m_ovf) : 32'd0);
        check_val("underflow", 32'(underflow), ERR_EN ? 32'(m_unf) : 32'd0);
    endtask

    // One clock cycle of stimulus; model advances from the pre-edge state.
    task automatic cyc(input logic we, input logic [1:0] wc, input logic [DW-1:0] wd,
                       input logic re, input logic [1:0] rc, input logic [CH-1:0] fl,
                       input logic clr);
        logic          exp_v;
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_c;
        logic [CH-1:0] os, us;
        int            wsz;
        wr_en = we; wr_ch = wc; wr_data = wd;
        rd_en = re; rd_ch = rc; ch_flush = fl; err_clr = clr;
        exp_v = 1'b0; exp_d = '0; exp_c = '0; os = '0; us = '0;
        wsz = mq[wc].size();
        if (re && !fl[rc]) begin
            if (mq[rc].size() == 0) begin
                us[rc] = 1'b1;
            end else begin
                exp_v = 1'b1;
                exp_d = mq[rc].pop_front();
                exp_c = rc;
            end
        end
        if (we && !fl[wc]) begin
            if (wsz == D) os[wc] = 1'b1;
            else mq[wc].push_back(wd);
        end
        for (int c = 0; c < CH; c++) begin
            if (fl[c]) mq[c].delete();
        end
        m_ovf = os | (m_ovf & ~{CH{clr}});
        m_unf = us | (m_unf & ~{CH{clr}});
        @(posedge clk);
        #1;
        check_val("rd_valid", 32'(rd_valid), 32'(exp_v));
        if (exp_v) begin
            check_val("rd_data", 32'(rd_data), 32'(exp_d));
            check_val("rd_data_ch", 32'(rd_data_ch), 32'(exp_c));
        end
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b0);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_empty", 32'(empty), 32'hF);
        check_val("reset_rd_valid", 32'(rd_valid), 32'd0);
        check_val("reset_rd_data", 32'(rd_data), 32'd0);
        check_val("reset_rd_data_ch", 32'(rd_data_ch), 32'd0);
        check_state();

        // Fill ch2 to full, then one dropped write, then drain
        for (int i = 0; i < D; i++) cyc(1'b1, 2'd2, DW'(16'h2000 + i), 1'b0, 2'd0, '0, 1'b0);
        cyc(1'b1, 2'd2, 16'hDEAD, 1'b0, 2'd0, '0, 1'b0);
        check_val("ch2_full", 32'(full[2]), 32'd1);
        for (int i = 0; i < D; i++) cyc(1'b0, 2'd0, '0, 1'b1, 2'd2, '0, 1'b0);
        cyc(1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b1);

        // Interleave ch0 / ch3
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'd0, DW'(16'hA0 + i), 1'b0, 2'd0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'd3, DW'(16'hB0 + i), 1'b0, 2'd0, '0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 2'd0, '0, 1'b1, (i % 2) ? 2'd3 : 2'd0, '0, 1'b0);

        // Same-cycle write+read on ch1 at count 5, across pointer wrap
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd1, DW'(16'h1000 + i), 1'b0, 2'd0, '0, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 2'd1, DW'($urandom), 1'b1, 2'd1, '0, 1'b0);
        check_val("ch1_not_aempty", 32'(almost_empty[1]), 32'd0);

        // Flush ch1 at count 10 while writing ch1 and reading ch0
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd1, DW'($urandom), 1'b0, 2'd0, '0, 1'b0);
        cyc(1'b1, 2'd0, 16'hC0DE, 1'b0, 2'd0, '0, 1'b0);
        cyc(1'b1, 2'd1, 16'hBAD1, 1'b1, 2'd0, 4'b0010, 1'b0);
        check_val("flush_ch1_empty", 32'(empty[1]), 32'd1);
        check_val("flush_ch0_read", 32'(rd_data), 32'hC0DE);

        // Read empty ch0, then clear errors
        cyc(1'b0, 2'd0, '0, 1'b1, 2'd0, '0, 1'b0);
        cyc(1'b0, 2'd0, '0, 1'b0, 2'd0, '0, 1'b1);

        // Random traffic, alternating write-heavy and read-heavy windows
        for (int i = 0; i < 4000; i++) begin
            int            wp;
            logic [CH-1:0] fl;
            wp = ((i / 400) % 2) ? 75 : 35;
            for (int b = 0; b < CH; b++) fl[b] = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 99) < wp, 2'($urandom_range(0, 3)), DW'($urandom),
                $urandom_range(0, 99) < (100 - wp), 2'($urandom_range(0, 3)), fl,
                $urandom_range(0, 99) < 3);
        end

        // Reset mid-operation cancels an in-flight rd_valid
        cyc(1'b1, 2'd0, 16'h5A5A, 1'b0, 2'd0, '0, 1'b0);
        cyc(1'b0, 2'd0, '0, 1'b1, 2'd0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) mq[c].delete();
        m_ovf = '0;
        m_unf = '0;
        check_val("async_rst_rd_valid", 32'(rd_valid), 32'd0);
        check_val("async_rst_rd_data", 32'(rd_data), 32'd0);
        check_state();
        #2 rst_n = 1'b1;
        idle(2);
        cyc(1'b1, 2'd3, 16'h7777, 1'b0, 2'd0, '0, 1'b0);
        cyc(1'b0, 2'd0, '0, 1'b1, 2'd3, '0, 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
